// File: rtl/pipeline_5_ma.sv
// Memory-access stage: finishes the AHB data phase of loads/stores issued by EX,
// aligns load data, stalls EX on wait states and reports bus faults/timeouts.
//
// state | meaning
// RUN   | no data phase outstanding beyond the current cycle
// WAIT  | data phase extended by slave wait states, watchdog counting
// ERR2  | second cycle of a two-cycle AHB error response
// DRAIN | killed or timed-out access; wait for hready, discard everything
module pipeline_5_ma #(
  parameter int MAX_WAIT = 0,
  parameter int CNT_W    = 16
) (
  input  logic        s_clk_i,
  input  logic        s_rst_i,
  input  logic        s_flush_i,
  input  logic [31:0] s_exma_val_i,
  input  logic [31:0] s_exma_payload_i,
  input  logic [4:0]  s_exma_rd_i,
  input  logic [3:0]  s_exma_f_i,
  input  logic        s_exma_lsu_i,
  input  logic        s_exma_wen_i,
  input  logic [31:0] s_hrdata_i,
  input  logic        s_hready_i,
  input  logic        s_hresp_i,
  output logic        s_stall_o,
  output logic        s_flush_o,
  output logic        s_exc_o,
  output logic [3:0]  s_exc_cause_o,
  output logic [31:0] s_exc_addr_o,
  output logic [31:0] s_mawb_val_o,
  output logic [4:0]  s_mawb_rd_o,
  output logic        s_mawb_wen_o
);

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_ERR2, ST_DRAIN} state_e;

  localparam logic [CNT_W:0] MAX_WAIT_C = (CNT_W+1)'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W:0]    cnt_inc;
  logic              wait_hit;
  logic [31:0]       val_q, val_d;
  logic [4:0]        rd_q, rd_d;
  logic              wen_q, wen_d;

  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_val;
  logic              sext;
  logic              retire;
  logic              raise;
  logic              stall;

  always_comb begin
    sext = ~s_exma_f_i[2];
    case (s_exma_payload_i[1:0])
      2'd0:    ld_byte = s_hrdata_i[7:0];
      2'd1:    ld_byte = s_hrdata_i[15:8];
      2'd2:    ld_byte = s_hrdata_i[23:16];
      default: ld_byte = s_hrdata_i[31:24];
    endcase
    ld_half = s_exma_payload_i[1] ? s_hrdata_i[31:16] : s_hrdata_i[15:0];
    case (s_exma_f_i[1:0])
      2'd0:    ld_val = {{24{sext & ld_byte[7]}}, ld_byte};
      2'd1:    ld_val = {{16{sext & ld_half[15]}}, ld_half};
      default: ld_val = s_hrdata_i;
    endcase
  end

  // cnt_q counts wait states already elapsed; this cycle would be number cnt_q+1
  assign cnt_inc  = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign wait_hit = (MAX_WAIT != 0) && (cnt_inc == MAX_WAIT_C);

  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    val_d         = val_q;
    rd_d          = rd_q;
    wen_d         = 1'b0;
    retire        = 1'b0;
    raise         = 1'b0;
    stall         = 1'b0;
    s_stall_o     = 1'b0;
    s_flush_o     = 1'b0;
    s_exc_o       = 1'b0;
    s_exc_cause_o = 4'd0;
    s_exc_addr_o  = 32'd0;

    case (state_q)
      ST_RUN: begin
        if (!s_exma_lsu_i) begin
          val_d = s_exma_val_i;
          rd_d  = s_exma_rd_i;
          wen_d = s_exma_wen_i & ~s_flush_i;
        end else if (s_hready_i) begin
          retire = ~s_flush_i;
        end else begin
          stall = 1'b1;
          if (s_hresp_i) state_d = ST_ERR2;
          else if (wait_hit) begin
            raise   = 1'b1;
            state_d = ST_DRAIN;
          end else if (s_flush_i) state_d = ST_DRAIN;
          else begin
            state_d = ST_WAIT;
            cnt_d   = cnt_inc[CNT_W-1:0];
          end
        end
      end
      ST_WAIT: begin
        if (s_hready_i) begin
          retire  = ~s_flush_i;
          state_d = ST_RUN;
        end else begin
          stall = 1'b1;
          if (s_hresp_i) state_d = ST_ERR2;
          else if (wait_hit) begin
            raise   = 1'b1;
            state_d = ST_DRAIN;
          end else if (s_flush_i) state_d = ST_DRAIN;
          else cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      ST_ERR2: begin
        if (s_hready_i) begin
          raise   = ~s_flush_i;
          state_d = ST_RUN;
        end else begin
          stall = 1'b1;
          if (s_flush_i) state_d = ST_DRAIN;
        end
      end
      default: begin
        if (s_hready_i) state_d = ST_RUN;
        else stall = 1'b1;
      end
    endcase

    if (retire) begin
      val_d = s_exma_f_i[3] ? s_exma_val_i : ld_val;
      rd_d  = s_exma_rd_i;
      wen_d = s_exma_wen_i & ~s_exma_f_i[3];
    end

    // Strobes are combinational, so they must be forced low while reset is held
    if (!s_rst_i) begin
      s_stall_o = stall;
      if (raise) begin
        s_exc_o       = 1'b1;
        s_flush_o     = 1'b1;
        s_exc_cause_o = s_exma_f_i[3] ? 4'd7 : 4'd5;
        s_exc_addr_o  = s_exma_payload_i;
      end
    end
  end

  always_ff @(posedge s_clk_i or posedge s_rst_i) begin
    if (s_rst_i) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      val_q   <= '0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      rd_q    <= rd_d;
      wen_q   <= wen_d;
    end
  end

  assign s_mawb_val_o = val_q;
  assign s_mawb_rd_o  = rd_q;
  assign s_mawb_wen_o = wen_q;

endmodule
